// File: rtl/bta_pipe_adder.sv
// Fully pipelined N-operand binary-tree adder with valid/ready flow control.
// Level j holds N/2^j partial sums of M+j bits, so the final M+log2(N) bit sum is exact.
module bta_pipe_adder #(
    parameter int N = 16,
    parameter int M = 16
) (
    input  logic                       clk,
    input  logic                       rst_n,
    input  logic                       in_valid,
    output logic                       in_ready,
    input  logic [N*M-1:0]             operands,
    input  logic                       sgn,
    input  logic                       cin,
    output logic                       out_valid,
    input  logic                       out_ready,
    output logic [M+$clog2(N)-1:0]     sum,
    output logic                       sgn_out
);
    localparam int L = $clog2(N);

    logic adv;

    // One global enable: every level (bubble or not) moves together, so the
    // pipeline stalls only when the output register is occupied and not taken.
    assign adv      = !out_valid || out_ready;
    assign in_ready = adv;

    genvar j;
    generate
        for (j = 1; j <= L; j++) begin : g_lvl
            localparam int W = M + j;
            localparam int C = N >> j;

            logic [W-1:0] ps  [C];
            logic [W-1:0] nxt [C];
            logic         vld;
            logic         sg;
            logic         prev_vld;
            logic         prev_sg;

            if (j == 1) begin : g_in
                assign prev_vld = in_valid;
                assign prev_sg  = sgn;

                always_comb begin
                    for (int k = 0; k < C; k++) begin
                        nxt[k] = {sgn & operands[2*k*M+M-1], operands[2*k*M +: M]}
                               + {sgn & operands[(2*k+1)*M+M-1], operands[(2*k+1)*M +: M]}
                               + ((k == 0) ? {{(W-1){1'b0}}, cin} : {W{1'b0}});
                    end
                end
            end else begin : g_mid
                assign prev_vld = g_lvl[j-1].vld;
                assign prev_sg  = g_lvl[j-1].sg;

                always_comb begin
                    for (int k = 0; k < C; k++) begin
                        nxt[k] = {prev_sg & g_lvl[j-1].ps[2*k][W-2],   g_lvl[j-1].ps[2*k]}
                               + {prev_sg & g_lvl[j-1].ps[2*k+1][W-2], g_lvl[j-1].ps[2*k+1]};
                    end
                end
            end

            always_ff @(posedge clk or negedge rst_n) begin
                if (!rst_n) begin
                    ps  <= '{default: '0};
                    vld <= 1'b0;
                    sg  <= 1'b0;
                end else if (adv) begin
                    ps  <= nxt;
                    vld <= prev_vld;
                    sg  <= prev_sg;
                end
            end
        end
    endgenerate

    assign sum       = g_lvl[L].ps[0];
    assign out_valid = g_lvl[L].vld;
    assign sgn_out   = g_lvl[L].sg;

endmodule

// File: tb/tb_bta_pipe_adder.sv
// Directed bench for bta_pipe_adder (N=16, M=16): extremes, ramp, streaming,
// back-pressure hold and mid-flight reset, with hand-computed expected sums.
module tb_bta_pipe_adder;
    localparam int N  = 16;
    localparam int M  = 16;
    localparam int SW = 20;

    logic            clk = 1'b0;
    logic            rst_n;
    logic            in_valid;
    logic            in_ready;
    logic [N*M-1:0]  operands;
    logic            sgn;
    logic            cin;
    logic            out_valid;
    logic            out_ready;
    logic [SW-1:0]   sum;
    logic            sgn_out;

    int n_cmp = 0;
    int n_err = 0;
    int cyc   = 0;

    logic [SW-1:0] rx_sum [$];
    logic          rx_sgn [$];
    int            rx_cyc [$];

    bta_pipe_adder #(.N(N), .M(M)) dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .operands  (operands),
        .sgn       (sgn),
        .cin       (cin),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .sum       (sum),
        .sgn_out   (sgn_out)
    );

    always #5 clk = ~clk;
    always @(posedge clk) cyc++;

    // Records every result transfer; inputs only change just after posedge.
    always @(negedge clk) begin
        if (rst_n && out_valid && out_ready) begin
            rx_sum.push_back(sum);
            rx_sgn.push_back(sgn_out);
            rx_cyc.push_back(cyc);
        end
    end

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_cmp++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    function automatic logic [N*M-1:0] fill(input logic [M-1:0] v);
        logic [N*M-1:0] r;
        for (int k = 0; k < N; k++) r[k*M +: M] = v;
        return r;
    endfunction

    function automatic logic [N*M-1:0] ramp(input int base);
        logic [N*M-1:0] r;
        for (int k = 0; k < N; k++) r[k*M +: M] = M'(base + k);
        return r;
    endfunction

    function automatic void clear_rx();
        rx_sum.delete();
        rx_sgn.delete();
        rx_cyc.delete();
    endfunction

    // Call shortly after a posedge; returns 1 ns after the accepting edge.
    task automatic send(input logic [N*M-1:0] ops, input logic sg, input logic ci);
        int w = 0;
        bit acc = 1'b0;
        operands = ops;
        sgn      = sg;
        cin      = ci;
        in_valid = 1'b1;
        while (!acc && w < 50) begin
            @(negedge clk);
            acc = in_ready;
            @(posedge clk);
            #1;
            w++;
        end
        in_valid = 1'b0;
        if (!acc) chk("send_timeout", 32'd0, 32'd1);
    endtask

    // Single transaction: check latency (edges counted from the accept edge), sum and sgn_out.
    task automatic run1(input string tag, input logic [N*M-1:0] ops, input logic sg,
                        input logic ci, input logic [SW-1:0] exp_sum);
        int cnt;
        send(ops, sg, ci);
        cnt = 1;
        while (!out_valid && cnt < 20) begin
            @(posedge clk);
            #1;
            cnt++;
        end
        chk({tag, "_lat"}, cnt, 32'd4);
        chk({tag, "_sum"}, 32'(sum), 32'(exp_sum));
        chk({tag, "_sgn"}, 32'(sgn_out), 32'(sg));
        @(posedge clk);
        #1;
    endtask

    int exp_stream [8] = '{120, 136, 152, 168, 184, 200, 216, 232};
    int exp_bp     [6] = '{280, 296, 312, 328, 344, 360};

    initial begin
        rst_n     = 1'b0;
        in_valid  = 1'b0;
        operands  = '0;
        sgn       = 1'b0;
        cin       = 1'b0;
        out_ready = 1'b1;
        #22;
        chk("rst_out_valid", 32'(out_valid), 32'd0);
        chk("rst_in_ready",  32'(in_ready),  32'd1);
        chk("rst_sum",       32'(sum),       32'd0);
        chk("rst_sgn_out",   32'(sgn_out),   32'd0);
        rst_n = 1'b1;
        @(posedge clk);
        #1;

        run1("umax",     fill(16'hFFFF), 1'b0, 1'b1, 20'hFFFF1);
        run1("smin",     fill(16'h8000), 1'b1, 1'b0, 20'h80000);
        run1("smax",     fill(16'h7FFF), 1'b1, 1'b1, 20'h7FFF1);
        run1("sneg1",    fill(16'hFFFF), 1'b1, 1'b0, 20'hFFFF0);
        run1("ramp_u",   ramp(0),        1'b0, 1'b0, 20'h00078);
        run1("ramp_s",   ramp(0),        1'b1, 1'b0, 20'h00078);

        // Streaming: 8 back-to-back transactions, alternating sgn.
        clear_rx();
        for (int t = 0; t < 8; t++) send(ramp(t), t[0], 1'b0);
        repeat (8) @(posedge clk);
        #1;
        chk("stream_count", rx_sum.size(), 32'd8);
        for (int i = 0; i < 8 && i < rx_sum.size(); i++) begin
            chk($sformatf("stream_sum%0d", i), 32'(rx_sum[i]), exp_stream[i]);
            chk($sformatf("stream_sgn%0d", i), 32'(rx_sgn[i]), 32'(i % 2));
            chk($sformatf("stream_cyc%0d", i), rx_cyc[i] - rx_cyc[0], i);
        end

        // Back-pressure: fill all four levels, hold three cycles with junk on the inputs.
        out_ready = 1'b0;
        for (int t = 10; t < 14; t++) send(ramp(t), t[0], 1'b0);
        operands = fill(16'h1234);
        sgn      = 1'b1;
        in_valid = 1'b1;
        for (int h = 0; h < 3; h++) begin
            @(negedge clk);
            chk($sformatf("bp_in_ready%0d", h),  32'(in_ready),  32'd0);
            chk($sformatf("bp_out_valid%0d", h), 32'(out_valid), 32'd1);
            chk($sformatf("bp_sum%0d", h),       32'(sum),       32'd280);
            chk($sformatf("bp_sgn%0d", h),       32'(sgn_out),   32'd0);
            @(posedge clk);
            #1;
        end
        in_valid = 1'b0;
        clear_rx();
        out_ready = 1'b1;
        for (int t = 14; t < 16; t++) send(ramp(t), t[0], 1'b0);
        repeat (8) @(posedge clk);
        #1;
        chk("bp_count", rx_sum.size(), 32'd6);
        for (int i = 0; i < 6 && i < rx_sum.size(); i++) begin
            chk($sformatf("bp_drain_sum%0d", i), 32'(rx_sum[i]), exp_bp[i]);
            chk($sformatf("bp_drain_sgn%0d", i), 32'(rx_sgn[i]), 32'(i % 2));
        end

        // Reset with three transactions in flight.
        for (int t = 20; t < 23; t++) send(ramp(t), 1'b0, 1'b0);
        rst_n = 1'b0;
        #1;
        chk("mrst_out_valid", 32'(out_valid), 32'd0);
        chk("mrst_sum",       32'(sum),       32'd0);
        chk("mrst_in_ready",  32'(in_ready),  32'd1);
        #13;
        rst_n = 1'b1;
        clear_rx();
        repeat (6) @(posedge clk);
        #1;
        chk("mrst_no_stale", rx_sum.size(), 32'd0);
        run1("post_rst", ramp(3), 1'b1, 1'b1, 20'd169);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL global_timeout: got running expected finished");
        $fatal(1, "timeout");
    end
endmodule

// File: doc/bta_pipe_adder.md
Name: bta_pipe_adder

Overview:
- Parametrised, fully pipelined multi-operand binary-tree adder. It reduces N operands of M bits to one exact sum.
- It is the next generation of the team's fixed 16-operand/16-bit tree adder. It adds valid/ready flow control, back-pressure, a signed/unsigned mode per transaction, and a single carry-in.
- It sits between operand-producing datapath blocks and accumulator/consumer logic.

Parameters:
- N, 16, operand count. Must be a power of two, 2..64. L = log2(N) is the number of tree levels.
- M, 16, operand width in bits, 4..32.

Ports:
- clk  in  1  rising-edge clock
- rst_n  in  1  asynchronous, active-low reset
- in_valid  in  1  operand set and mode valid
- in_ready  out  1  block accepts an operand set this cycle
- operands  in  N*M  flat bus; operand k occupies bits [k*M+M-1 : k*M]
- sgn  in  1  1 = operands are two's complement; 0 = unsigned. Sampled with the operands.
- cin  in  1  carry-in, added exactly once per transaction
- out_valid  out  1  sum valid
- out_ready  in  1  consumer accepts sum
- sum  out  M+L  exact sum of all operands plus cin; two's complement when sgn=1
- sgn_out  out  1  sgn of the transaction currently on sum

Behaviour:
- Accept rule: a transfer occurs when in_valid && in_ready. A result transfer occurs when out_valid && out_ready.
- Global advance enable: adv = !out_valid || out_ready.
  - in_ready = adv, driven combinationally from output state only. It never depends on in_valid.
- Pipeline structure: level j (1..L) holds N/2^j partial sums of M+j bits, one register per level.
  - Each level register carries a valid bit and the transaction's sgn.
  - All levels shift only when adv=1. When adv=0 every level holds.
  - Bubbles are not collapsed. A level with valid=0 still shifts.
- Level 1 operation:
  - Operands are extended to M+1 bits: sign-extended when sgn=1, zero-extended when sgn=0.
  - Adjacent pairs (2k, 2k+1) are added.
  - cin is added into pair 0 only.
- Level j>1: adds adjacent pairs of level j-1 results after extending them by one bit. Extension is sign or zero according to the stage's sgn.
- Latency and throughput:
  - Latency is exactly L cycles from the accept edge to out_valid=1, when there is no stall.
  - Throughput is one transaction per cycle.
- Width: M+L bits is exact for every input.
  - No overflow is possible, including the unsigned maximum N*(2^M-1)+1 and the signed extremes.
  - No carry-out port exists.
- Ordering: results emerge in accept order. No transaction is lost or duplicated.
- Hold under back-pressure: while out_valid=1 and out_ready=0, sum and sgn_out are held stable.
- Boundaries:
  - Empty pipeline: out_valid=0 and in_ready=1. sum holds its last value; it is don't-care for the consumer.
  - Full pipeline with out_ready=0: in_ready=0. Stimulus on operands is ignored.
  - Simultaneous accept and emit when full and out_ready=1: both transfers occur in the same cycle.
- Reset (rst_n low, asynchronous):
  - All level valid bits clear immediately, so out_valid=0.
  - sum=0, sgn_out=0, all partial-sum registers=0.
  - in_ready=1 while in reset.
  - Reset mid-operation discards all in-flight transactions.
  - Normal operation resumes on the first rising clk after rst_n deasserts.

Test Plan:
- Unsigned maximum (N=16, M=16): all operands 0xFFFF, sgn=0, cin=1 -> sum=0xFFFF1 (1048561), out_valid exactly 4 cycles after accept.
- Signed extreme: all operands 0x8000, sgn=1, cin=0 -> sum=0x80000 (-524288), sgn_out=1. Then all operands 0x7FFF with cin=1 -> sum=0x7FFF1.
- Ramp: operand k=k for k=0..15, sgn=0, cin=0 -> sum=0x00078 (120). Same operands with sgn=1 -> sum=0x00078 (120) and sgn_out=1.
- Streaming: 8 back-to-back transactions with out_ready=1, alternating sgn, operand k = t+k -> 8 consecutive result cycles, in order, each equal to 16t+120, with sgn_out matching.
- Back-pressure: fill the pipeline, drop out_ready for 3 cycles -> in_ready=0 and sum/sgn_out held for those 3 cycles. Raise out_ready -> remaining results drain in order with no loss or duplication.
- Reset mid-flight: assert rst_n=0 with 3 transactions in flight -> out_valid=0 and sum=0 asynchronously. After release, no stale result appears and a new transaction returns its correct sum 4 cycles after accept.
